trigger_controller: RTL and testbench

Acquisition trigger sequencer for the oscilloscope datapath. It watches the ADC sample stream and generates the one-cycle `trigger_o` pulse that closes each min/max measurement window in the computation block. It supports level/hysteresis edge detection, holdoff, auto-trigger timeout and single-shot arming. It also reports the trigger period in samples for frequency display.

---
 rtl/trigger_controller_pkg.sv | 21 ++
 rtl/trigger_controller_sat_counter.sv | 35 +++
 rtl/trigger_controller.sv | 162 ++++++++++++++++
 tb/tb_trigger_controller.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/trigger_controller_pkg.sv
// Shared acquisition constants and encodings
// for the trigger sequencer and computation block.
package trigger_controller_pkg;

  localparam int DATA_SIZE = 12;

  typedef enum logic [1:0] {
    MODE_OFF    = 2'd0,
    MODE_NORMAL = 2'd1,
    MODE_AUTO   = 2'd2,
    MODE_SINGLE = 2'd3
  } mode_e;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ARMING  = 2'd1,
    ST_READY   = 2'd2,
    ST_HOLDOFF = 2'd3
  } state_e;

endpackage

// File: rtl/trigger_controller_sat_counter.sv
// Saturating up-counter with synchronous clear.
// Clear has priority over enable.
module sat_counter #(
  parameter int CNT_SIZE = 16
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                clr_i,
  input  logic                en_i,
  output logic [CNT_SIZE-1:0] cnt_o
);

  logic [CNT_SIZE-1:0] cnt_q;
  logic [CNT_SIZE-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i && !(&cnt_q)) begin
      cnt_d = cnt_q + CNT_SIZE'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/trigger_controller.sv
// Trigger sequencer: level/hysteresis edge detect,
// holdoff, auto timeout, single shot, period measure.
module trigger_controller #(
  parameter int DATA_SIZE = trigger_controller_pkg::DATA_SIZE,
  parameter int CNT_SIZE  = 16,
  parameter int HYST      = 16
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 sample_valid_i,
  input  logic [DATA_SIZE-1:0] sample_data_i,
  input  logic [DATA_SIZE-1:0] level_i,
  input  logic [1:0]           mode_i,
  input  logic                 arm_i,
  input  logic [CNT_SIZE-1:0]  holdoff_i,
  input  logic [CNT_SIZE-1:0]  auto_timeout_i,
  output logic                 trigger_o,
  output logic                 auto_o,
  output logic [CNT_SIZE-1:0]  period_o,
  output logic                 period_valid_o,
  output logic [1:0]           state_o
);

  import trigger_controller_pkg::*;

  mode_e  mode;
  state_e state_q, state_d;

  logic [DATA_SIZE-1:0] thr;
  logic [31:0]          lvl_w;
  logic [CNT_SIZE-1:0]  hcnt, tcnt, pcnt, pinc;
  logic [CNT_SIZE:0]    hnext;
  logic real_trig, force_trig, tout_hit, active;
  logic hist_q, hist_d;
  logic trig_q, trig_d;
  logic auto_q, auto_d;
  logic pv_q, pv_d;
  logic [CNT_SIZE-1:0] period_q, period_d;

  assign mode  = mode_e'(mode_i);
  assign lvl_w = 32'(level_i);
  assign thr   = (lvl_w >= 32'(HYST)) ?
                 DATA_SIZE'(lvl_w - 32'(HYST)) : '0;

  assign active = (state_q == ST_ARMING) ||
                  (state_q == ST_READY);
  assign hnext  = {1'b0, hcnt} + (CNT_SIZE+1)'(1);
  assign pinc   = (&pcnt) ? pcnt : pcnt + CNT_SIZE'(1);

  assign tout_hit = sample_valid_i && active &&
                    (mode == MODE_AUTO) &&
                    (auto_timeout_i != '0) &&
                    (tcnt >= auto_timeout_i);

  sat_counter #(.CNT_SIZE(CNT_SIZE)) u_hold (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .clr_i (state_q != ST_HOLDOFF),
    .en_i  (sample_valid_i),
    .cnt_o (hcnt)
  );

  sat_counter #(.CNT_SIZE(CNT_SIZE)) u_tout (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .clr_i (!active || real_trig || force_trig),
    .en_i  (sample_valid_i),
    .cnt_o (tcnt)
  );

  sat_counter #(.CNT_SIZE(CNT_SIZE)) u_per (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .clr_i (real_trig),
    .en_i  (sample_valid_i),
    .cnt_o (pcnt)
  );

  always_comb begin
    state_d    = state_q;
    real_trig  = 1'b0;
    force_trig = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (mode == MODE_SINGLE) begin
          if (arm_i) state_d = ST_ARMING;
        end else if (sample_valid_i &&
                     (mode == MODE_NORMAL ||
                      mode == MODE_AUTO)) begin
          state_d = ST_ARMING;
        end
      end
      ST_ARMING: begin
        if (sample_valid_i &&
            (sample_data_i < thr || thr == '0)) begin
          state_d = ST_READY;
        end
      end
      ST_READY: begin
        if (sample_valid_i && sample_data_i >= level_i) begin
          real_trig = 1'b1;
          state_d   = (mode == MODE_SINGLE) ?
                      ST_IDLE : ST_HOLDOFF;
        end
      end
      ST_HOLDOFF: begin
        if (sample_valid_i &&
            hnext >= {1'b0, holdoff_i}) begin
          state_d = ST_ARMING;
        end
      end
    endcase
    // A real crossing on the timeout sample wins.
    if (tout_hit && !real_trig) begin
      force_trig = 1'b1;
      state_d    = ST_HOLDOFF;
    end
    if (mode == MODE_OFF) begin
      state_d    = ST_IDLE;
      real_trig  = 1'b0;
      force_trig = 1'b0;
    end
  end

  always_comb begin
    hist_d = hist_q;
    if (state_q == ST_IDLE || mode == MODE_OFF) begin
      hist_d = 1'b0;
    end else if (real_trig) begin
      hist_d = 1'b1;
    end
    trig_d   = real_trig || force_trig;
    auto_d   = force_trig;
    pv_d     = real_trig && hist_q;
    period_d = pv_d ? pinc : period_q;
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q  <= ST_IDLE;
      hist_q   <= 1'b0;
      trig_q   <= 1'b0;
      auto_q   <= 1'b0;
      pv_q     <= 1'b0;
      period_q <= '0;
    end else begin
      state_q  <= state_d;
      hist_q   <= hist_d;
      trig_q   <= trig_d;
      auto_q   <= auto_d;
      pv_q     <= pv_d;
      period_q <= period_d;
    end
  end

  assign trigger_o      = trig_q;
  assign auto_o         = auto_q;
  assign period_valid_o = pv_q;
  assign period_o       = period_q;
  assign state_o        = state_q;

endmodule

// File: tb/tb_trigger_controller.sv
// Directed bench for trigger_controller.
// Expected values are hand-derived constants.
module tb_trigger_controller;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        valid = 1'b0;
  logic [11:0] data = '0;
  logic [11:0] level = 12'd2000;
  logic [1:0]  mode = 2'd0;
  logic        arm = 1'b0;
  logic [15:0] holdoff = '0;
  logic [15:0] tout = '0;
  logic        trig, auto_s, pv;
  logic [15:0] period;
  logic [1:0]  state;

  int checks = 0;
  int fails = 0;
  int vidx = 0;
  int trig_n, auto_n, pv_n, orphan_n;
  int last_t, last_sp, min_sp;

  always #5 clk = ~clk;

  trigger_controller dut (
    .clk_i          (clk),
    .rst_i          (rst),
    .sample_valid_i (valid),
    .sample_data_i  (data),
    .level_i        (level),
    .mode_i         (mode),
    .arm_i          (arm),
    .holdoff_i      (holdoff),
    .auto_timeout_i (tout),
    .trigger_o      (trig),
    .auto_o         (auto_s),
    .period_o       (period),
    .period_valid_o (pv),
    .state_o        (state)
  );

  task automatic chk(input string tag,
                     input int got, input int exp);
    checks++;
    if (got != exp) begin
      fails++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  function automatic logic [11:0] tri_s(input int k);
    int p;
    p = k % 100;
    if (p <= 50) return 12'(p * 81);
    return 12'((100 - p) * 81);
  endfunction

  task automatic clr_stats();
    trig_n   = 0;
    auto_n   = 0;
    pv_n     = 0;
    last_t   = -1;
    last_sp  = 0;
    min_sp   = 1 << 30;
  endtask

  task automatic step(input logic v, input logic [11:0] d);
    valid = v;
    data  = d;
    @(posedge clk);
    #1;
    if (auto_s) auto_n++;
    if (trig) begin
      trig_n++;
      if (last_t >= 0) begin
        last_sp = vidx - last_t;
        if (last_sp < min_sp) min_sp = last_sp;
      end
      last_t = vidx;
    end
    if (pv) begin
      pv_n++;
      if (!trig) orphan_n++;
    end
    if (v) vidx++;
  endtask

  task automatic go_off();
    mode = 2'd0;
    step(1'b0, 12'd0);
    chk("off_state", state, 0);
  endtask

  initial begin
    orphan_n = 0;
    clr_stats();
    repeat (3) @(posedge clk);
    #1;
    chk("rst_trig", trig, 0);
    chk("rst_auto", auto_s, 0);
    chk("rst_pv", pv, 0);
    chk("rst_period", period, 0);
    chk("rst_state", state, 0);
    rst = 1'b1;

    // normal mode, triangle of period 100
    mode = 2'd1;
    clr_stats();
    for (int k = 0; k < 500; k++) step(1'b1, tri_s(k));
    chk("nrm_trig", trig_n, 5);
    chk("nrm_auto", auto_n, 0);
    chk("nrm_pv", pv_n, 4);
    chk("nrm_period", period, 100);
    chk("nrm_space", last_sp, 100);

    // hysteresis
    go_off();
    mode = 2'd1;
    clr_stats();
    step(1'b1, 12'd0);
    step(1'b1, 12'd0);
    step(1'b1, 12'd2005);
    for (int i = 0; i < 20; i++)
      step(1'b1, (i % 2 == 1) ? 12'd2005 : 12'd1990);
    chk("hys_hold_trig", trig_n, 1);
    chk("hys_first_pv", pv_n, 0);
    step(1'b1, 12'd1983);
    step(1'b1, 12'd2005);
    chk("hys_trig", trig_n, 2);
    chk("hys_pv", pv_n, 1);
    chk("hys_period", period, 22);

    // auto mode, constant input
    go_off();
    mode = 2'd2;
    tout = 16'd50;
    clr_stats();
    for (int k = 0; k < 270; k++) step(1'b1, 12'd100);
    chk("auto_trig", trig_n, 5);
    chk("auto_flag", auto_n, 5);
    chk("auto_pv", pv_n, 0);
    chk("auto_space", last_sp, 52);
    tout = 16'd0;

    // single shot
    go_off();
    mode = 2'd3;
    clr_stats();
    for (int k = 0; k < 5; k++) step(1'b1, tri_s(30));
    chk("sgl_idle", state, 0);
    for (int n = 0; n < 2; n++) begin
      arm = 1'b1;
      step(1'b0, 12'd0);
      arm = 1'b0;
      chk("sgl_armed", state, 1);
      for (int k = 0; k < 200; k++) step(1'b1, tri_s(k));
      chk("sgl_trig", trig_n, n + 1);
      chk("sgl_state", state, 0);
    end
    chk("sgl_auto", auto_n, 0);
    chk("sgl_pv", pv_n, 0);

    // holdoff 30, crossing every 10 samples
    go_off();
    mode = 2'd1;
    holdoff = 16'd30;
    clr_stats();
    for (int k = 0; k < 160; k++)
      step(1'b1, (k % 10 == 0) ? 12'd3000 : 12'd0);
    chk("hld_trig", trig_n, 4);
    chk("hld_pv", pv_n, 3);
    chk("hld_period", period, 40);
    chk("hld_minsp", min_sp, 40);
    holdoff = 16'd0;

    // stalls: every valid sample followed by garbage
    go_off();
    mode = 2'd1;
    clr_stats();
    for (int k = 0; k < 300; k++) begin
      step(1'b1, tri_s(k));
      step(1'b0, 12'hFFF);
    end
    chk("stl_trig", trig_n, 3);
    chk("stl_pv", pv_n, 2);
    chk("stl_period", period, 100);
    chk("stl_space", last_sp, 100);

    // reset while READY
    go_off();
    mode = 2'd1;
    clr_stats();
    for (int k = 0; k <= 80; k++) step(1'b1, tri_s(k));
    chk("rr_pre_trig", trig_n, 1);
    chk("rr_pre_state", state, 2);
    rst = 1'b0;
    #1;
    chk("rr_state", state, 0);
    chk("rr_period", period, 0);
    chk("rr_trig", trig, 0);
    @(posedge clk);
    #1;
    rst = 1'b1;
    clr_stats();
    step(1'b0, 12'd0);
    chk("rr_rel_trig", trig, 0);
    chk("rr_rel_pv", pv, 0);
    for (int k = 81; k <= 125; k++) step(1'b1, tri_s(k));
    chk("rr_first_trig", trig_n, 1);
    chk("rr_first_pv", pv_n, 0);
    for (int k = 126; k <= 225; k++) step(1'b1, tri_s(k));
    chk("rr_second_trig", trig_n, 2);
    chk("rr_second_pv", pv_n, 1);
    chk("rr_period2", period, 100);

    chk("pv_orphan", orphan_n, 0);
    $display("TB_RESULT checks=%0d failures=%0d",
             checks, fails);
    $finish;
  end

endmodule
